word_slicer: RTL and testbench

Wide-to-narrow width converter: accepts one WORD_W-bit word per valid/ready handshake and emits it as a stream of SLICE_W-bit slices, LSB slice first, with a last marker. It is the narrowing counterpart of the codebase's slice-replicating and widening assignments. It sits between a word-oriented producer and a narrow serial consumer, for example a bit-pair link or a nibble bus. Back-to-back words stream with no idle cycle.

---
 rtl/word_slicer_pkg.sv | 24 ++
 rtl/word_slicer.sv | 87 ++++++++
 tb/tb_word_slicer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/word_slicer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : word_slicer_pkg
// Brief    : Shared types and helpers for the word_slicer width converter.
// Revision : 1.0 - initial release
// ============================================================================
package word_slicer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } word_slicer_state_t;

  // A requested length of 0, or anything past the slice count, means a full word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned nslice);
    return (len == 0 || len > nslice) ? nslice : len;
  endfunction

  function automatic bit width_ok(input int unsigned word_w, input int unsigned slice_w);
    return (slice_w != 0) && ((word_w % slice_w) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/word_slicer.sv
`default_nettype none
// ============================================================================
// Module   : word_slicer
// Brief    : Wide-to-narrow converter, emits each word as LSB-first slices.
// Revision : 1.0 - initial release
// ============================================================================
module word_slicer
  import word_slicer_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int SLICE_W = 2,
  parameter int NSLICE  = WORD_W / SLICE_W,
  parameter int LEN_W   = $clog2(NSLICE + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [LEN_W-1:0]   in_len,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic               out_last,
  output logic [LEN_W-1:0]   out_idx
);

  localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

  generate
    if (!width_ok(WORD_W, SLICE_W)) begin : g_bad_width
      $error("word_slicer: WORD_W must be a non-zero multiple of SLICE_W");
    end
  endgenerate

  word_slicer_state_t r_state;
  logic [WORD_W-1:0]  r_hold;
  logic [LEN_W-1:0]   r_len;

  logic               w_accept;
  logic               w_out_hs;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_idx_next;
  logic [WORD_W-1:0]  w_shift;

  // No path from in_valid: ready depends only on state and the last-slice handshake.
  assign in_ready   = (r_state == IDLE) | (out_valid & out_ready & out_last);
  assign w_accept   = in_valid & in_ready;
  assign w_out_hs   = out_valid & out_ready;
  assign w_len      = LEN_W'(eff_len(32'(in_len), 32'(NSLICE)));
  assign w_idx_next = out_idx + c_one;
  assign w_shift    = r_hold >> SLICE_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_len     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else if (w_accept) begin
      // Also covers the zero-bubble reload on a last-slice handshake.
      r_state   <= SHIFT;
      r_hold    <= in_data;
      r_len     <= w_len;
      out_valid <= 1'b1;
      out_data  <= in_data[SLICE_W-1:0];
      out_last  <= (w_len == c_one);
      out_idx   <= '0;
    end else if (w_out_hs) begin
      if (out_last) begin
        r_state   <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        r_hold   <= w_shift;
        out_data <= w_shift[SLICE_W-1:0];
        out_idx  <= w_idx_next;
        out_last <= (w_idx_next == (r_len - c_one));
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_word_slicer.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_slicer
// Brief    : Self-checking bench for word_slicer against a slice-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_slicer;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int N  = 4;
  localparam int LW = 3;

  typedef struct packed {
    logic [S-1:0]  d;
    logic [LW-1:0] idx;
    logic          last;
    logic          rdy;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [S-1:0]  out_data;
  logic          out_last;
  logic [LW-1:0] out_idx;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    rand_mode = 1'b0;
  beat_t obs[$];
  int    obs_cyc[$];
  beat_t exp_q[$];

  word_slicer #(.WORD_W(W), .SLICE_W(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_idx(out_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so a negedge sample shows the coming handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      obs.push_back({out_data, out_idx, out_last, in_ready});
      obs_cyc.push_back(cyc);
    end
  end

  // Model: slice i of a word is simply bits [S*i +: S]; ready must be high exactly on the last one.
  function automatic void expect_word(input logic [W-1:0] d, input int len);
    int n = (len == 0 || len > N) ? N : len;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] v;
      v = d >> (S * i);
      exp_q.push_back({v[S-1:0], LW'(i), (i == n - 1), (i == n - 1)});
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int len);
    in_valid = 1'b1;
    in_data  = d;
    in_len   = LW'(len);
    for (int t = 0; t < 100; t++) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready) begin
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    checks++; errors++;
    $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      #1;
      if (!out_valid) begin
        out_ready = 1'b1;
        return;
      end
      step();
    end
    checks++; errors++;
    $display("FAIL drain_timeout out_valid=%0b required=0", out_valid);
    out_ready = 1'b1;
  endtask

  task automatic clear();
    obs.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({out_valid, out_data, out_last, out_idx, in_ready} !== {1'b0, 2'd0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%0b d=%0d l=%0b i=%0d r=%0b required v=0 d=0 l=0 i=0 r=1",
               out_valid, out_data, out_last, out_idx, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    clear();
    expect_word(8'hB4, 4);
    send(8'hB4, 4);
    drain();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL basic_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL basic_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
    checks++;
    if ({in_ready, out_last, out_idx, out_data} !== {1'b1, 1'b0, exp_q[3].idx, exp_q[3].d}) begin
      errors++;
      $display("FAIL basic_idle got r=%0b l=%0b i=%0d d=%0d required r=1 l=0 i=%0d d=%0d",
               in_ready, out_last, out_idx, out_data, exp_q[3].idx, exp_q[3].d);
    end
  endtask

  task automatic test_clamp();
    logic [W-1:0] d;
    clear();
    expect_word(8'hFF, 0); send(8'hFF, 0); drain();
    expect_word(8'hE4, 2); send(8'hE4, 2); drain();
    for (int l = 5; l < 8; l++) begin
      d = W'($urandom);
      expect_word(d, l); send(d, l); drain();
    end
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL clamp_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL clamp_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    clear();
    expect_word(8'h1B, 4); expect_word(8'hE4, 4);
    send(8'h1B, 4);
    send(8'hE4, 4);
    drain();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== obs_cyc[i-1] + 1) begin errors++; $display("FAIL b2b_gap%0d got cycle %0d required %0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
    end
  endtask

  task automatic test_backpressure();
    clear();
    expect_word(8'hB4, 4);
    send(8'hB4, 4);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({out_valid, out_data, out_idx, out_last, in_ready} !== {1'b1, exp_q[1].d, exp_q[1].idx, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall%0d got v=%0b d=%0d i=%0d l=%0b r=%0b required v=1 d=%0d i=%0d l=0 r=0",
                 k, out_valid, out_data, out_idx, out_last, in_ready, exp_q[1].d, exp_q[1].idx);
      end
      step();
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_word();
    clear();
    expect_word(8'hB4, 4);
    exp_q = exp_q[0:0];
    send(8'hB4, 4);
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_idx, in_ready} !== {1'b0, 2'd0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL midreset got v=%0b d=%0d i=%0d r=%0b required v=0 d=0 i=0 r=1",
               out_valid, out_data, out_idx, in_ready);
    end
    step();
    rst_n = 1'b1;
    expect_word(8'h03, 1);
    send(8'h03, 1);
    drain();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL midreset_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL midreset_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_single_slice();
    clear();
    for (int k = 1; k <= 3; k++) begin
      expect_word(W'(k), 1);
      send(W'(k), 1);
    end
    drain();
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL single_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      checks++;
      if (obs_cyc[i] !== obs_cyc[i-1] + 1) begin errors++; $display("FAIL single_gap%0d got cycle %0d required %0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d;
    int           l;
    clear();
    rand_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d = W'($urandom);
      l = $urandom_range(0, 7);
      expect_word(d, l);
      send(d, l);
    end
    drain();
    rand_mode = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat%0d got %h required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_single_slice();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
